// File: rtl/acc_breg_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the 8-bit ALU datapath: ALU op codes, sequencer
//   command encodings and the sequencer FSM state encoding. The ALU and the
//   instruction decoder import the same package, so these encodings must not
//   be renumbered here without updating both of them.
//
//   Contents:
//     alu_op_e     ALU op codes ADD..BXR (3'b000..3'b111)
//     cmd_e        sequencer commands LDA/LDB/EXE/CLR (2'b00..2'b11)
//     seq_state_e  sequencer FSM states IDLE/EXEC/WB
//     WAIT_CW      width of the ALU latency wait counter (latency 1..7)
//     is_arith     op codes whose result can overflow (ADD/SUB/DEC/INC)
//     is_unit_op   op codes whose second operand is the constant 1
//     is_sub_op    op codes that subtract their second operand
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    DEC = 3'b010,
    INC = 3'b011,
    OC  = 3'b100,
    BND = 3'b101,
    BOR = 3'b110,
    BXR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    LDA = 2'b00,
    LDB = 2'b01,
    EXE = 2'b10,
    CLR = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } seq_state_e;

  // A latency of up to 7 edges needs a counter that can hold 6.
  localparam int WAIT_CW = 3;

  function automatic logic is_arith(input alu_op_e op);
    return (op == ADD) || (op == SUB) || (op == DEC) || (op == INC);
  endfunction

  function automatic logic is_unit_op(input alu_op_e op);
    return (op == DEC) || (op == INC);
  endfunction

  function automatic logic is_sub_op(input alu_op_e op);
    return (op == SUB) || (op == DEC);
  endfunction

endpackage

// File: rtl/acc_breg_sequencer_if.sv
// ---------------------------------------------------------------------------
// acc_breg_sequencer_if
//   Command channel into the accumulator / B register sequencer. A command
//   transfers on a rising clock edge where CMD_valid and CMD_ready are both
//   high; the source holds CMD, CMD_op and CMD_data stable until then.
//
//   Signals:
//     CMD_valid  source -> sequencer  command present
//     CMD_ready  sequencer -> source  command can be accepted this cycle
//     CMD        source -> sequencer  LDA / LDB / EXE / CLR
//     CMD_op     source -> sequencer  ALU op code used by EXE
//     CMD_data   source -> sequencer  load value for LDA / LDB
//
//   Modports:
//     master  command source (instruction decoder or testbench)
//     slave   the sequencer
// ---------------------------------------------------------------------------
interface acc_breg_sequencer_if
  import alu_pkg::*;
#(
  parameter int DW = 8
);

  logic          CMD_valid;
  logic          CMD_ready;
  cmd_e          CMD;
  alu_op_e       CMD_op;
  logic [DW-1:0] CMD_data;

  modport master (
    output CMD_valid,
    output CMD,
    output CMD_op,
    output CMD_data,
    input  CMD_ready
  );

  modport slave (
    input  CMD_valid,
    input  CMD,
    input  CMD_op,
    input  CMD_data,
    output CMD_ready
  );

endinterface

// File: rtl/acc_breg_sequencer_flag_gen.sv
// ---------------------------------------------------------------------------
// alu_flag_gen
//   Combinational status-flag generator for the value about to be written
//   into the accumulator. The sequencer feeds it CMD_data on the LDA path and
//   ALU_in on the writeback path, so one instance serves both.
//
//   Optional feature macro: ACC_OVF_FLAG_EN
//     When defined, the block also produces the signed overflow flag for the
//     arithmetic op codes, derived from the operand signs and the sign of the
//     ALU result (the ALU itself does not report overflow).
//
//   Ports:
//     value      in   DW  value being written into the accumulator
//     acc        in   DW  accumulator operand of the op (ACC_OVF_FLAG_EN only)
//     operand_b  in   DW  B register operand of the op  (ACC_OVF_FLAG_EN only)
//     op         in   3   op code that produced value   (ACC_OVF_FLAG_EN only)
//     flag_v     out  1   signed overflow               (ACC_OVF_FLAG_EN only)
//     flag_z     out  1   value == 0
//     flag_n     out  1   value[DW-1]
// ---------------------------------------------------------------------------
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] value,
`ifdef ACC_OVF_FLAG_EN
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] operand_b,
  input  alu_op_e       op,
  output logic          flag_v,
`endif
  output logic          flag_z,
  output logic          flag_n
);

  assign flag_z = (value == '0);
  assign flag_n = value[DW-1];

`ifdef ACC_OVF_FLAG_EN
  logic [DW-1:0] operand;
  logic          sign_a;
  logic          sign_b;
  logic          sign_r;

  // DEC and INC work against the constant 1 rather than the B register.
  // Addition overflows when both operands share a sign the result lacks;
  // subtraction overflows when the operands differ in sign and the result
  // sign differs from the accumulator's.
  always_comb begin
    operand = is_unit_op(op) ? DW'(1) : operand_b;
    sign_a  = acc[DW-1];
    sign_b  = operand[DW-1];
    sign_r  = value[DW-1];
    flag_v  = 1'b0;
    if (is_arith(op)) begin
      if (is_sub_op(op)) begin
        flag_v = (sign_a != sign_b) && (sign_r != sign_a);
      end else begin
        flag_v = (sign_a == sign_b) && (sign_r != sign_a);
      end
    end
  end
`endif

endmodule

// File: rtl/acc_breg_sequencer.sv
// ---------------------------------------------------------------------------
// acc_breg_sequencer
//   Operand/control stage in front of the 8-bit signed ALU. Holds the
//   accumulator and B register, accepts LDA/LDB/EXE/CLR commands over a
//   valid/ready channel, presents operands and op code to the ALU, waits out
//   the ALU's registered latency and writes the ALU result back into the
//   accumulator. Z/N (and optionally V) flags describe the last accumulator
//   write and feed the branch logic.
//
//   Optional feature macro: ACC_OVF_FLAG_EN
//     Adds the FLAG_V output: signed overflow of ADD/SUB/DEC/INC at
//     writeback, cleared by the logical ops, LDA and CLR, untouched by LDB.
//
//   Parameters:
//     DW       datapath width (8 for the current ALU)
//     ALU_LAT  clock edges from OP_out valid to ALU_in valid, 1..7
//
//   Ports:
//     CLK        in   1   clock, rising edge
//     RST_N      in   1   synchronous active-low reset
//     cmd_if     slave    command channel (CMD_valid/ready, CMD, CMD_op,
//                         CMD_data)
//     Acc_out    out  DW  accumulator, ALU accumulator input
//     Breg_out   out  DW  B register, ALU B input
//     OP_out     out  3   op code presented to the ALU
//     ALU_OE     out  1   ALU output enable
//     ALU_in     in   DW  ALU result bus
//     BUSY       out  1   EXE in flight
//     FLAG_Z     out  1   accumulator == 0 after the last write
//     FLAG_N     out  1   accumulator sign after the last write
//     FLAG_V     out  1   signed overflow (ACC_OVF_FLAG_EN only)
// ---------------------------------------------------------------------------
module acc_breg_sequencer
  import alu_pkg::*;
#(
  parameter int DW      = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  acc_breg_sequencer_if.slave  cmd_if,
  output logic [DW-1:0]        Acc_out,
  output logic [DW-1:0]        Breg_out,
  output logic [2:0]           OP_out,
  output logic                 ALU_OE,
  input  logic [DW-1:0]        ALU_in,
  output logic                 BUSY,
  output logic                 FLAG_Z,
  output logic                 FLAG_N
`ifdef ACC_OVF_FLAG_EN
  ,
  output logic                 FLAG_V
`endif
);

  seq_state_e         state;
  seq_state_e         state_nxt;
  logic [WAIT_CW-1:0] wait_cnt;

  logic               xfer;
  logic               do_lda;
  logic               do_ldb;
  logic               do_clr;
  logic               do_exe;
  logic               do_oe;
  logic               do_wb;

  logic [DW-1:0]      flag_val;
  logic               gen_z;
  logic               gen_n;
`ifdef ACC_OVF_FLAG_EN
  logic               gen_v;
`endif

  // Ready is asserted only in IDLE and is forced low while reset is held so
  // that nothing can transfer on a reset edge.
  assign cmd_if.CMD_ready = (state == IDLE) && RST_N;
  assign xfer             = cmd_if.CMD_valid && cmd_if.CMD_ready;

  // Next-state and one-cycle action strobes. Each strobe marks the edge on
  // which the corresponding register update takes effect.
  always_comb begin
    state_nxt = state;
    do_lda    = 1'b0;
    do_ldb    = 1'b0;
    do_clr    = 1'b0;
    do_exe    = 1'b0;
    do_oe     = 1'b0;
    do_wb     = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          case (cmd_if.CMD)
            LDA: do_lda = 1'b1;
            LDB: do_ldb = 1'b1;
            CLR: do_clr = 1'b1;
            EXE: begin
              do_exe    = 1'b1;
              state_nxt = EXEC;
            end
            default: ;
          endcase
        end
      end
      EXEC: begin
        if (wait_cnt == '0) begin
          do_oe     = 1'b1;
          state_nxt = WB;
        end
      end
      WB: begin
        do_wb     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ALU latency counter: loaded on the EXE transfer so that it reaches zero
  // on the edge before ALU_in becomes valid, then counts down in EXEC.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wait_cnt <= '0;
    end else if (do_exe) begin
      wait_cnt <= WAIT_CW'(ALU_LAT - 1);
    end else if ((state == EXEC) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // In WB the flag generator looks at the ALU result; everywhere else it
  // looks at the incoming load value, which only matters for LDA.
  assign flag_val = (state == WB) ? ALU_in : cmd_if.CMD_data;

  alu_flag_gen #(
    .DW(DW)
  ) u_flag_gen (
    .value     (flag_val),
`ifdef ACC_OVF_FLAG_EN
    .acc       (Acc_out),
    .operand_b (Breg_out),
    .op        (alu_op_e'(OP_out)),
    .flag_v    (gen_v),
`endif
    .flag_z    (gen_z),
    .flag_n    (gen_n)
  );

  // Operand, op code, handshake-status and flag registers. Acc_out,
  // Breg_out and OP_out are only written from IDLE or WB, so they stay
  // stable while the ALU is computing. Reset discards any EXE in flight.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      Acc_out  <= '0;
      Breg_out <= '0;
      OP_out   <= '0;
      ALU_OE   <= 1'b0;
      BUSY     <= 1'b0;
      FLAG_Z   <= 1'b1;
      FLAG_N   <= 1'b0;
`ifdef ACC_OVF_FLAG_EN
      FLAG_V   <= 1'b0;
`endif
    end else begin
      if (do_lda) begin
        Acc_out <= cmd_if.CMD_data;
        FLAG_Z  <= gen_z;
        FLAG_N  <= gen_n;
`ifdef ACC_OVF_FLAG_EN
        FLAG_V  <= 1'b0;
`endif
      end
      if (do_ldb) begin
        Breg_out <= cmd_if.CMD_data;
      end
      if (do_clr) begin
        Acc_out  <= '0;
        Breg_out <= '0;
        FLAG_Z   <= 1'b1;
        FLAG_N   <= 1'b0;
`ifdef ACC_OVF_FLAG_EN
        FLAG_V   <= 1'b0;
`endif
      end
      if (do_exe) begin
        OP_out <= cmd_if.CMD_op;
        BUSY   <= 1'b1;
      end
      if (do_oe) begin
        ALU_OE <= 1'b1;
      end
      if (do_wb) begin
        Acc_out <= ALU_in;
        FLAG_Z  <= gen_z;
        FLAG_N  <= gen_n;
        ALU_OE  <= 1'b0;
        BUSY    <= 1'b0;
`ifdef ACC_OVF_FLAG_EN
        FLAG_V  <= gen_v;
`endif
      end
    end
  end

endmodule

// File: tb/tb_acc_breg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_acc_breg_sequencer
//   Self-checking bench for acc_breg_sequencer with ALU_LAT = 1, paired with
//   a registered behavioural ALU. Expected writebacks are queued when an EXE
//   is issued and compared when BUSY falls after a writeback edge.
//   Define ACC_OVF_FLAG_EN to build and check the FLAG_V variant.
// ---------------------------------------------------------------------------
module tb_acc_breg_sequencer;
  import alu_pkg::*;

  localparam int DW      = 8;
  localparam int ALU_LAT = 1;

  typedef struct packed {
    logic [7:0] acc;
    logic       z;
    logic       n;
    logic       v;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] Acc_out;
  logic [7:0] Breg_out;
  logic [2:0] OP_out;
  logic       ALU_OE;
  logic [7:0] ALU_in;
  logic [7:0] alu_q;
  logic       BUSY;
  logic       FLAG_Z;
  logic       FLAG_N;
`ifdef ACC_OVF_FLAG_EN
  logic       FLAG_V;
`endif

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];
  logic busy_d   = 1'b0;
  logic rst_seen = 1'b0;

  acc_breg_sequencer_if #(.DW(DW)) cmd_bus ();

  acc_breg_sequencer #(
    .DW      (DW),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .cmd_if   (cmd_bus),
    .Acc_out  (Acc_out),
    .Breg_out (Breg_out),
    .OP_out   (OP_out),
    .ALU_OE   (ALU_OE),
    .ALU_in   (ALU_in),
    .BUSY     (BUSY),
    .FLAG_Z   (FLAG_Z),
    .FLAG_N   (FLAG_N)
`ifdef ACC_OVF_FLAG_EN
    ,
    .FLAG_V   (FLAG_V)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] alu_result(input logic [7:0] a, input logic [7:0] b,
                                            input alu_op_e op);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      DEC:     return a - 8'd1;
      INC:     return a + 8'd1;
      OC:      return ~a;
      BND:     return a & b;
      BOR:     return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Expected writeback: overflow judged by doing the arithmetic in int range.
  function automatic exp_t model_exe(input logic [7:0] a, input logic [7:0] b,
                                     input alu_op_e op);
    exp_t e;
    int   sa;
    int   sbv;
    int   t;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    case (op)
      ADD:     t = sa + sbv;
      SUB:     t = sa - sbv;
      DEC:     t = sa - 1;
      INC:     t = sa + 1;
      default: t = 0;
    endcase
    e.acc = alu_result(a, b, op);
    e.z   = (e.acc == 8'h00);
    e.n   = e.acc[7];
    e.v   = (t > 127) || (t < -128);
    return e;
  endfunction

  // Behavioural ALU: one register stage, drives the bus only when enabled.
  always @(posedge CLK) alu_q <= alu_result(Acc_out, Breg_out, alu_op_e'(OP_out));
  assign ALU_in = ALU_OE ? alu_q : 8'h00;

  // Scoreboard monitor: a writeback is recognised by BUSY falling across an
  // edge that was not a reset edge.
  always @(posedge CLK) rst_seen <= RST_N;

  always @(negedge CLK) begin
    exp_t e;
    if (busy_d && !BUSY && rst_seen) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL wb_unexpected: Acc_out=%h written with no expected entry", Acc_out);
      end else begin
        e = sb.pop_front();
        if ({Acc_out, FLAG_Z, FLAG_N} !== {e.acc, e.z, e.n}) begin
          miscompares++;
          $display("[TB] FAIL wb_result: got Acc_out=%h Z=%b N=%b, expected Acc_out=%h Z=%b N=%b",
                   Acc_out, FLAG_Z, FLAG_N, e.acc, e.z, e.n);
        end
`ifdef ACC_OVF_FLAG_EN
        vectors++;
        if (FLAG_V !== e.v) begin
          miscompares++;
          $display("[TB] FAIL wb_flag_v: got FLAG_V=%b, expected %b (Acc_out=%h)", FLAG_V, e.v, Acc_out);
        end
`endif
      end
    end
    busy_d <= BUSY;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one command from a negedge, wait (bounded) for the transfer edge
  // and return at the negedge after it with CMD_valid dropped.
  task automatic send(input cmd_e c, input alu_op_e op, input logic [7:0] d);
    int w;
    w = 0;
    cmd_bus.CMD_valid = 1'b1;
    cmd_bus.CMD       = c;
    cmd_bus.CMD_op    = op;
    cmd_bus.CMD_data  = d;
    while (cmd_bus.CMD_ready !== 1'b1 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    if (cmd_bus.CMD_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL send_timeout: CMD_ready=%b after %0d cycles, expected 1", cmd_bus.CMD_ready, w);
    end
    @(posedge CLK);
    @(negedge CLK);
    cmd_bus.CMD_valid = 1'b0;
  endtask

  // Count cycles with CMD_ready low (and ALU_OE high among them) until the
  // sequencer is idle again; bounded.
  task automatic wait_idle(output int low_cycles, output int oe_cycles);
    low_cycles = 0;
    oe_cycles  = 0;
    while (cmd_bus.CMD_ready !== 1'b1 && low_cycles < 20) begin
      if (ALU_OE === 1'b1) oe_cycles++;
      low_cycles++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST_N             = 1'b0;
    cmd_bus.CMD_valid = 1'b1;
    cmd_bus.CMD       = LDA;
    cmd_bus.CMD_op    = INC;
    cmd_bus.CMD_data  = 8'hFF;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if ({Acc_out, Breg_out, OP_out} !== 19'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_regs: got Acc=%h Breg=%h OP=%h, expected all 0", Acc_out, Breg_out, OP_out);
    end
    vectors++;
    if ({ALU_OE, BUSY, FLAG_Z, FLAG_N} !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL reset_status: got OE=%b BUSY=%b Z=%b N=%b, expected 0 0 1 0",
               ALU_OE, BUSY, FLAG_Z, FLAG_N);
    end
`ifdef ACC_OVF_FLAG_EN
    vectors++;
    if (FLAG_V !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flag_v: got %b, expected 0", FLAG_V);
    end
`endif
    vectors++;
    if (cmd_bus.CMD_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got CMD_ready=%b during reset, expected 0", cmd_bus.CMD_ready);
    end
    cmd_bus.CMD_valid = 1'b0;
    RST_N             = 1'b1;
    @(negedge CLK);
    vectors++;
    if (cmd_bus.CMD_ready !== 1'b1 || Acc_out !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got ready=%b Acc=%h, expected ready=1 Acc=00",
               cmd_bus.CMD_ready, Acc_out);
    end
  endtask

  task automatic test_add();
    int low;
    int oe;
    send(LDA, ADD, 8'h05);
    vectors++;
    if ({Acc_out, FLAG_Z, FLAG_N} !== {8'h05, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL lda_05: got Acc=%h Z=%b N=%b, expected 05 0 0", Acc_out, FLAG_Z, FLAG_N);
    end
    send(LDB, ADD, 8'h03);
    vectors++;
    if (Breg_out !== 8'h03) begin
      miscompares++;
      $display("[TB] FAIL ldb_03: got Breg=%h, expected 03", Breg_out);
    end
    sb.push_back('{acc: 8'h08, z: 1'b0, n: 1'b0, v: 1'b0});
    send(EXE, ADD, 8'h00);
    vectors++;
    if (OP_out !== 3'(ADD) || BUSY !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL exe_issue: got OP=%h BUSY=%b, expected 0 1", OP_out, BUSY);
    end
    wait_idle(low, oe);
    vectors++;
    if (low !== 2) begin
      miscompares++;
      $display("[TB] FAIL ready_low_cycles: got %0d, expected 2", low);
    end
    vectors++;
    if (oe !== 1) begin
      miscompares++;
      $display("[TB] FAIL oe_cycles: got %0d, expected 1", oe);
    end
    vectors++;
    if (Acc_out !== 8'h08 || ALU_OE !== 1'b0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL add_result: got Acc=%h OE=%b BUSY=%b, expected 08 0 0", Acc_out, ALU_OE, BUSY);
    end
  endtask

  task automatic test_inc_overflow();
    int low;
    int oe;
    send(LDA, ADD, 8'h7F);
    sb.push_back('{acc: 8'h80, z: 1'b0, n: 1'b1, v: 1'b1});
    send(EXE, INC, 8'h00);
    wait_idle(low, oe);
    vectors++;
    if ({Acc_out, FLAG_N} !== {8'h80, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL inc_7f: got Acc=%h N=%b, expected 80 1", Acc_out, FLAG_N);
    end
  endtask

  task automatic test_sub_dec();
    int low;
    int oe;
    send(LDA, ADD, 8'h03);
`ifdef ACC_OVF_FLAG_EN
    vectors++;
    if (FLAG_V !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lda_clears_v: got FLAG_V=%b, expected 0", FLAG_V);
    end
`endif
    send(LDB, ADD, 8'h03);
    sb.push_back('{acc: 8'h00, z: 1'b1, n: 1'b0, v: 1'b0});
    send(EXE, SUB, 8'h00);
    wait_idle(low, oe);
    send(LDA, ADD, 8'h00);
    vectors++;
    if ({FLAG_Z, FLAG_N} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL lda_00_flags: got Z=%b N=%b, expected 1 0", FLAG_Z, FLAG_N);
    end
    sb.push_back('{acc: 8'hFF, z: 1'b0, n: 1'b1, v: 1'b0});
    send(EXE, DEC, 8'h00);
    wait_idle(low, oe);
  endtask

  task automatic test_logic_ops();
    logic [7:0] ta [6] = '{8'hF0, 8'hF0, 8'hF0, 8'h5A, 8'h80, 8'h80};
    logic [7:0] tbv[6] = '{8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h80, 8'h01};
    alu_op_e    top[6] = '{BND, BOR, BXR, OC, ADD, SUB};
    int low;
    int oe;
    for (int i = 0; i < 6; i++) begin
      send(LDA, ADD, ta[i]);
      send(LDB, ADD, tbv[i]);
      sb.push_back(model_exe(ta[i], tbv[i], top[i]));
      send(EXE, top[i], 8'h00);
      wait_idle(low, oe);
    end
    send(CLR, ADD, 8'h55);
    vectors++;
    if ({Acc_out, Breg_out, FLAG_Z, FLAG_N} !== {16'h0000, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL clr: got Acc=%h Breg=%h Z=%b N=%b, expected 00 00 1 0",
               Acc_out, Breg_out, FLAG_Z, FLAG_N);
    end
  endtask

  task automatic test_backpressure();
    int c;
    int low;
    int oe;
    send(LDA, ADD, 8'h10);
    send(LDB, ADD, 8'h22);
    sb.push_back(model_exe(8'h10, 8'h22, BXR));
    send(EXE, BXR, 8'h00);
    cmd_bus.CMD_valid = 1'b1;
    cmd_bus.CMD       = LDB;
    cmd_bus.CMD_data  = 8'hAA;
    c = 0;
    while (cmd_bus.CMD_ready !== 1'b1 && c < 10) begin
      vectors++;
      if (Breg_out !== 8'h22) begin
        miscompares++;
        $display("[TB] FAIL bp_hold: got Breg=%h while busy, expected 22", Breg_out);
      end
      c++;
      @(negedge CLK);
    end
    vectors++;
    if (Breg_out !== 8'h22 || Acc_out !== 8'h32) begin
      miscompares++;
      $display("[TB] FAIL bp_after_wb: got Breg=%h Acc=%h, expected 22 32", Breg_out, Acc_out);
    end
    @(posedge CLK);
    @(negedge CLK);
    cmd_bus.CMD_valid = 1'b0;
    vectors++;
    if (Breg_out !== 8'hAA) begin
      miscompares++;
      $display("[TB] FAIL bp_accept: got Breg=%h, expected AA", Breg_out);
    end
    wait_idle(low, oe);
    vectors++;
    if (low !== 0 || BUSY !== 1'b0 || Acc_out !== 8'h32) begin
      miscompares++;
      $display("[TB] FAIL bp_single: got low=%0d BUSY=%b Acc=%h, expected 0 0 32", low, BUSY, Acc_out);
    end
  endtask

  task automatic test_back_to_back();
    int xfers;
    int first;
    int last;
    xfers = 0;
    first = 0;
    last  = 0;
    send(LDA, ADD, 8'h40);
    sb.push_back(model_exe(8'h40, 8'h00, INC));
    sb.push_back(model_exe(8'h41, 8'h00, INC));
    sb.push_back(model_exe(8'h42, 8'h00, INC));
    cmd_bus.CMD_valid = 1'b1;
    cmd_bus.CMD       = EXE;
    cmd_bus.CMD_op    = INC;
    cmd_bus.CMD_data  = 8'h00;
    for (int i = 0; i < 9; i++) begin
      if (cmd_bus.CMD_ready === 1'b1) begin
        if (xfers == 0) first = i;
        last = i;
        xfers++;
      end
      @(negedge CLK);
    end
    cmd_bus.CMD_valid = 1'b0;
    vectors++;
    if (xfers !== 3 || (last - first) !== 6) begin
      miscompares++;
      $display("[TB] FAIL b2b_rate: got %0d transfers spanning %0d cycles, expected 3 spanning 6",
               xfers, last - first);
    end
    vectors++;
    if (Acc_out !== 8'h43) begin
      miscompares++;
      $display("[TB] FAIL b2b_final: got Acc=%h, expected 43", Acc_out);
    end
  endtask

  task automatic test_reset_midop();
    send(LDA, ADD, 8'h33);
    send(LDB, ADD, 8'h11);
    send(EXE, ADD, 8'h00);
    RST_N = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({Acc_out, Breg_out, ALU_OE, BUSY, cmd_bus.CMD_ready} !== 19'h0) begin
      miscompares++;
      $display("[TB] FAIL midop_reset: got Acc=%h Breg=%h OE=%b BUSY=%b ready=%b, expected all 0",
               Acc_out, Breg_out, ALU_OE, BUSY, cmd_bus.CMD_ready);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    vectors++;
    if (cmd_bus.CMD_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midop_idle: got CMD_ready=%b after release, expected 1", cmd_bus.CMD_ready);
    end
    repeat (3) @(negedge CLK);
    vectors++;
    if ({Acc_out, ALU_OE, FLAG_Z} !== {8'h00, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL midop_no_wb: got Acc=%h OE=%b Z=%b, expected 00 0 1", Acc_out, ALU_OE, FLAG_Z);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_inc_overflow();
    test_sub_dec();
    test_logic_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    repeat (2) @(negedge CLK);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL sb_drain: got %0d pending writebacks, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
